// File: rtl/ft_stream_pkg.sv
// ============================================================================
// Module      : ft_stream_pkg
// Description : Shared types and constants for the FT2232H streaming
//               transmitter: FSM state encoding, source-mode values and the
//               frame sync bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ft_stream_pkg;

  // Transmitter states; HDR0/HDR1 are only reached with FT_STREAM_HDR_EN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR0 = 2'd1,
    ST_HDR1 = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic MODE_CTR    = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

endpackage

`default_nettype wire

// File: rtl/ft_stream_if.sv
// ============================================================================
// Module      : ft_stream_if
// Description : Bundles the external sample-source handshake and the FT2232H
//               synchronous FIFO write-side signals. The master modport is the
//               transmitter; the slave modport is the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ft_stream_if #(
  parameter int DATA_W = 16,
  parameter int NCHAN  = 2
);
  logic                    src_valid_i;
  logic                    src_ready_o;
  logic [NCHAN*DATA_W-1:0] src_data_i;
  logic                    ft_txe_n_i;
  logic                    ft_suspend_n_i;
  logic                    ft_wr_n_o;
  logic [7:0]              ft_data_o;

  modport master (
    input  src_valid_i, src_data_i, ft_txe_n_i, ft_suspend_n_i,
    output src_ready_o, ft_wr_n_o, ft_data_o
  );

  modport slave (
    output src_valid_i, src_data_i, ft_txe_n_i, ft_suspend_n_i,
    input  src_ready_o, ft_wr_n_o, ft_data_o
  );
endinterface

`default_nettype wire

// File: rtl/ft_stream_ser.sv
// ============================================================================
// Module      : ft_stream_ser
// Description : Byte serialiser. Loads a unit of 1..NBYTES bytes (first byte
//               in the top bits), presents one byte at a time on a registered
//               bus and tracks FIFO acceptance. A presented byte is held until
//               accepted; the next unit may be loaded on the same edge as the
//               final byte of the current one is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_stream_ser #(
  parameter int NBYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [$clog2(NBYTES+1)-1:0]  i_len,
  input  logic [NBYTES*8-1:0]          i_data,
  input  logic                         i_txe_n,
  input  logic                         i_suspend_n,
  output logic                         o_done,
  output logic                         o_empty,
  output logic                         o_wr_n,
  output logic [7:0]                   o_data
);

  localparam int c_CW = $clog2(NBYTES + 1);

  logic [c_CW-1:0]     r_cnt;   // bytes of the unit not yet accepted, incl. the presented one
  logic [NBYTES*8-1:0] r_sreg;  // bytes queued behind the presented one
  logic [7:0]          r_data;
  logic                r_wr_n;

  logic [c_CW-1:0]     w_cnt_nxt;
  logic [NBYTES*8-1:0] w_sreg_nxt;
  logic [7:0]          w_data_nxt;
  logic                w_acc;
  logic                w_take;

  assign w_acc   = ~r_wr_n & ~i_txe_n;
  assign o_done  = w_acc & (r_cnt == c_CW'(1));
  assign o_empty = (r_cnt == '0);
  assign w_take  = i_load & (o_empty | o_done);
  assign o_wr_n  = r_wr_n;
  assign o_data  = r_data;

  // Next presented byte: a fresh unit, the next queued byte, or hold.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_sreg_nxt = r_sreg;
    w_data_nxt = r_data;
    if (w_take) begin
      w_data_nxt = i_data[NBYTES*8-1 -: 8];
      w_sreg_nxt = i_data << 8;
      w_cnt_nxt  = i_len;
    end else if (w_acc) begin
      w_data_nxt = r_sreg[NBYTES*8-1 -: 8];
      w_sreg_nxt = r_sreg << 8;
      w_cnt_nxt  = r_cnt - c_CW'(1);
    end
  end

  // Output register; strobe only when a byte is pending and the FIFO can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sreg <= '0;
      r_data <= 8'h00;
      r_wr_n <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sreg <= w_sreg_nxt;
      r_data <= w_data_nxt;
      r_wr_n <= ~((w_cnt_nxt != '0) & ~i_txe_n & i_suspend_n);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft_stream_tx.sv
// ============================================================================
// Module      : ft_stream_tx
// Description : FT2232H streaming transmitter. Serialises sample sets from an
//               internal counter pattern or an external source into the
//               FT2232H synchronous FIFO, channel 0 first, MSB byte first.
//               Build option FT_STREAM_HDR_EN: when defined, every frame of
//               FRAME_LEN sample sets is preceded by the sync pair A5 5A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_stream_tx
  import ft_stream_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NCHAN     = 2,
  parameter int FRAME_LEN = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       mode_i,
  output logic       busy_o,
  ft_stream_if.master bus
);

  localparam int c_NBYTES = NCHAN * DATA_W / 8;
  localparam int c_CW     = $clog2(c_NBYTES + 1);
  localparam int c_SW     = NCHAN * DATA_W;

  state_t              r_state, w_state_nxt;
  logic                r_mode;
  logic [DATA_W-1:0]   r_ctr;
  logic [DATA_W-1:0]   w_cval;
  logic [c_SW-1:0]     w_ctr_set, w_src_set, w_set, w_ldata;
  logic [c_CW-1:0]     w_len;
  logic                w_load, w_want_set, w_set_avail, w_set_done;
  logic                w_ser_done, w_ser_empty;

`ifdef FT_STREAM_HDR_EN
  localparam int c_FW = $clog2(FRAME_LEN);
  logic [c_FW-1:0]     r_frm;
  logic                w_frm_last;
  logic [c_SW-1:0]     w_hdr0, w_hdr1;

  assign w_frm_last = (r_frm == c_FW'(FRAME_LEN - 1));

  // Sync bytes as single-byte units, aligned to the serialiser's first byte.
  always_comb begin
    w_hdr0 = '0;
    w_hdr1 = '0;
    w_hdr0[c_SW-1 -: 8] = SYNC0;
    w_hdr1[c_SW-1 -: 8] = SYNC1;
  end
`endif

  assign w_set_done  = (r_state == ST_DATA) & w_ser_done;
  // A set loaded on the edge that completes the previous one must see the advanced counter.
  assign w_cval      = w_set_done ? r_ctr + DATA_W'(1) : r_ctr;
  assign w_set_avail = (r_mode == MODE_CTR) | bus.src_valid_i;
  assign w_set       = (r_mode == MODE_STREAM) ? w_src_set : w_ctr_set;
  assign busy_o      = (r_state != ST_IDLE);
  assign bus.src_ready_o = w_want_set & (r_mode == MODE_STREAM);

  // Channel 0 goes to the top of the set so it leaves the serialiser first.
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    assign w_ctr_set[(NCHAN-1-c)*DATA_W +: DATA_W] = w_cval + DATA_W'(c);
    assign w_src_set[(NCHAN-1-c)*DATA_W +: DATA_W] = bus.src_data_i[c*DATA_W +: DATA_W];
  end

  // Next state and the unit to hand to the serialiser.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_want_set  = 1'b0;
    w_ldata     = w_set;
    w_len       = c_CW'(c_NBYTES);
    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
`ifdef FT_STREAM_HDR_EN
          w_state_nxt = ST_HDR0;
`else
          w_state_nxt = ST_DATA;
`endif
        end
      end
`ifdef FT_STREAM_HDR_EN
      ST_HDR0: begin
        if (w_ser_empty) begin
          if (en_i) begin
            w_load  = 1'b1;
            w_ldata = w_hdr0;
            w_len   = c_CW'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_ser_done) begin
          // The header pair is always completed once started.
          w_state_nxt = ST_HDR1;
          w_load      = 1'b1;
          w_ldata     = w_hdr1;
          w_len       = c_CW'(1);
        end
      end
      ST_HDR1: begin
        if (w_ser_done) begin
          if (en_i) begin
            w_state_nxt = ST_DATA;
            w_want_set  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
`endif
      ST_DATA: begin
        if (w_ser_empty || w_ser_done) begin
          if (!en_i) begin
            w_state_nxt = ST_IDLE;
`ifdef FT_STREAM_HDR_EN
          end else if (w_ser_done && w_frm_last) begin
            w_state_nxt = ST_HDR0;
            w_load      = 1'b1;
            w_ldata     = w_hdr0;
            w_len       = c_CW'(1);
`endif
          end else begin
            w_want_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_want_set) begin
      w_load = w_set_avail;
    end
  end

  // State, latched mode and the pattern/frame counters; all cleared while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_CTR;
      r_ctr   <= '0;
`ifdef FT_STREAM_HDR_EN
      r_frm   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        r_mode <= mode_i;
        r_ctr  <= '0;
`ifdef FT_STREAM_HDR_EN
        r_frm  <= '0;
`endif
      end else if (w_set_done) begin
        r_ctr <= r_ctr + DATA_W'(1);
`ifdef FT_STREAM_HDR_EN
        r_frm <= w_frm_last ? '0 : r_frm + c_FW'(1);
`endif
      end
    end
  end

  ft_stream_ser #(
    .NBYTES (c_NBYTES)
  ) u_ser (
    .clk         (clk_i),
    .rst         (rst_i),
    .i_load      (w_load),
    .i_len       (w_len),
    .i_data      (w_ldata),
    .i_txe_n     (bus.ft_txe_n_i),
    .i_suspend_n (bus.ft_suspend_n_i),
    .o_done      (w_ser_done),
    .o_empty     (w_ser_empty),
    .o_wr_n      (bus.ft_wr_n_o),
    .o_data      (bus.ft_data_o)
  );

endmodule

`default_nettype wire
